// File: rtl/serial_demux7_pkg.sv
// serial_demux7_pkg -- shared constants and FSM state type for serial_demux7.
//   WORD_W   : assembled word width (7 data bits)
//   IDX_W    : width of the write-slot index
//   LAST_IDX : last data slot; the write that lands here completes a word
//   state_t  : IDLE / FILL / HOLD, plus PAR when SERIAL_DEMUX7_PARITY_EN is defined
package serial_demux7_pkg;

   localparam int WORD_W = 7;
   localparam int IDX_W  = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = 3'd6;

`ifdef SERIAL_DEMUX7_PARITY_EN
   typedef enum logic [1:0] {IDLE, FILL, HOLD, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
`endif

endpackage

// File: rtl/serial_demux7_slot_decoder.sv
// slot_decoder -- turns the write-slot index into a one-hot write strobe.
//   index  : slot to write, 0..6
//   en     : write enable
//   strobe : one-hot strobe; all-zero when en=0 or index=7
module slot_decoder
   import serial_demux7_pkg::*;
(
   input  logic [IDX_W-1:0]  index,
   input  logic              en,
   output logic [WORD_W-1:0] strobe
);

   // Comparing against each slot number means index 7 matches nothing.
   always_comb begin
      strobe = '0;
      for (int k = 0; k < WORD_W; k++)
         strobe[k] = en && (index == IDX_W'(k));
   end

endmodule

// File: rtl/serial_demux7.sv
// serial_demux7 -- assembles serial bits (bit 0 first) into 7-bit words and
// holds each completed word until the consumer takes it.
//   Clock      : rising-edge clock
//   Resetn     : asynchronous active-low reset
//   bit_in     : serial data bit, qualified by bit_valid
//   bit_valid  : bit_in is valid this cycle
//   out_ready  : consumer takes out_data this cycle (only looked at in HOLD)
//   out_data   : assembled word, meaningful while out_valid=1
//   out_valid  : a complete word is held
//   index      : next write slot, 0..6
//   overrun    : sticky; a bit arrived while a word was held and not taken
//   parity_err : even-parity mismatch on the held word
// Optional feature: define SERIAL_DEMUX7_PARITY_EN to expect an even-parity
// bit after each 7-bit word (PAR state); otherwise parity_err is tied to 0.
module serial_demux7
   import serial_demux7_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   output logic [IDX_W-1:0]  index,
   output logic              overrun,
   output logic              parity_err
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic               wr_en;
   logic               ovr_set;
   logic [WORD_W-1:0]  strobe;
`ifdef SERIAL_DEMUX7_PARITY_EN
   logic               perr_nxt;
`endif

   slot_decoder u_slot_decoder (
      .index  (index),
      .en     (wr_en),
      .strobe (strobe)
   );

   // Word is presented straight from the state register, so out_valid rises
   // on the same edge that writes the last slot (or the parity bit).
   assign out_valid = (state == HOLD);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state    <= IDLE;
         index    <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         index    <= idx_nxt;
         // Only the strobed slot takes bit_in; every other slot holds.
         out_data <= (out_data & ~strobe) | ({WORD_W{bit_in}} & strobe);
         if (ovr_set)
            overrun <= 1'b1;
      end
   end

`ifdef SERIAL_DEMUX7_PARITY_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         parity_err <= 1'b0;
      else
         parity_err <= perr_nxt;
   end
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = index;
      wr_en     = 1'b0;
      ovr_set   = 1'b0;
`ifdef SERIAL_DEMUX7_PARITY_EN
      perr_nxt  = parity_err;
`endif
      case (state)
         IDLE: begin
            // index is 0 here, so the strobe lands on slot 0.
            if (bit_valid) begin
               wr_en     = 1'b1;
               idx_nxt   = 3'd1;
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (bit_valid) begin
               wr_en = 1'b1;
               if (index == LAST_IDX) begin
                  idx_nxt = '0;
`ifdef SERIAL_DEMUX7_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = HOLD;
`endif
               end else begin
                  idx_nxt = index + 3'd1;
               end
            end
         end
`ifdef SERIAL_DEMUX7_PARITY_EN
         PAR: begin
            // Even parity: data bits XOR parity bit must be 0.
            if (bit_valid) begin
               perr_nxt  = (^out_data) ^ bit_in;
               state_nxt = HOLD;
            end
         end
`endif
         HOLD: begin
            if (out_ready) begin
`ifdef SERIAL_DEMUX7_PARITY_EN
               perr_nxt = 1'b0;
`endif
               // A bit arriving with the handshake starts the next word;
               // index is already 0, so it lands in slot 0.
               if (bit_valid) begin
                  wr_en     = 1'b1;
                  idx_nxt   = 3'd1;
                  state_nxt = FILL;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (bit_valid) begin
               ovr_set = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_demux7.sv
// tb_serial_demux7 -- directed self-checking bench for serial_demux7.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_demux7;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [6:0] out_data;
   logic       out_valid;
   logic [2:0] index;
   logic       overrun;
   logic       parity_err;

   int errors = 0;
   int checks = 0;

   serial_demux7 dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .index      (index),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Stimulus only: shifts in 7 data bits (bit 0 first), then the parity
   // bit when the parity feature is built in.
   task automatic send_word(input logic [6:0] w, input logic par);
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1'b1;
         bit_in    = w[i];
         tick();
      end
`ifdef SERIAL_DEMUX7_PARITY_EN
      bit_valid = 1'b1;
      bit_in    = par;
      tick();
`else
      if (par) begin end
`endif
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      #3;
      checks++;
      if ({out_data, out_valid, index, overrun, parity_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%b valid=%b idx=%0d ovr=%b perr=%b, want all 0",
                  out_data, out_valid, index, overrun, parity_err);
      end
      tick();
      Resetn = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || index !== 3'd0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b idx=%0d, want 0 0", out_valid, index);
      end
   endtask

   task automatic test_fill();
      logic [6:0] bits;
      bits = 7'b1001101; // stream 1,0,1,1,0,0,1
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1'b1;
         bit_in    = bits[i];
         tick();
         if (i < 6) begin
            checks++;
            if (out_valid !== 1'b0 || index !== 3'(i + 1)) begin
               errors++;
               $display("FAIL fill_idx%0d: got valid=%b idx=%0d, want 0 %0d", i, out_valid, index, i + 1);
            end
         end
      end
`ifdef SERIAL_DEMUX7_PARITY_EN
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_par_wait: got valid=%b, want 0", out_valid);
      end
      bit_in = 1'b0; // four ones -> even parity bit 0
      tick();
`endif
      bit_valid = 1'b0;
      checks++;
      if (out_data !== 7'b1001101 || out_valid !== 1'b1 || index !== 3'd0 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL fill_word: got data=%b valid=%b idx=%0d perr=%b, want 1001101 1 0 0",
                  out_data, out_valid, index, parity_err);
      end
   endtask

   task automatic test_hold_wait();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_data !== 7'b1001101 || out_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait%0d: got data=%b valid=%b ovr=%b, want 1001101 1 0",
                     i, out_data, out_valid, overrun);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || index !== 3'd0) begin
         errors++;
         $display("FAIL hold_release: got valid=%b idx=%0d, want 0 0", out_valid, index);
      end
      // out_ready while idle must not change anything
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || index !== 3'd0) begin
         errors++;
         $display("FAIL idle_ready_ignored: got valid=%b idx=%0d, want 0 0", out_valid, index);
      end
   endtask

   task automatic test_back_to_back();
      send_word(7'b0101010, 1'b1); // three ones -> parity 1
      checks++;
      if (out_data !== 7'b0101010 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_word: got data=%b valid=%b, want 0101010 1", out_data, out_valid);
      end
      out_ready = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      out_ready = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || index !== 3'd1 || out_data !== 7'b0101011) begin
         errors++;
         $display("FAIL b2b_capture: got valid=%b idx=%0d data=%b, want 0 1 0101011",
                  out_valid, index, out_data);
      end
      // Finish the word with six zeros: slot 0 keeps the captured 1.
      for (int i = 0; i < 6; i++) begin
         bit_valid = 1'b1;
         tick();
      end
`ifdef SERIAL_DEMUX7_PARITY_EN
      bit_in = 1'b1; // one 1 -> parity 1
      tick();
      bit_in = 1'b0;
`endif
      bit_valid = 1'b0;
      checks++;
      if (out_data !== 7'b0000001 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_next_word: got data=%b valid=%b, want 0000001 1", out_data, out_valid);
      end
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      tick();
      bit_valid = 1'b0;
      checks++;
      if (overrun !== 1'b1 || out_data !== 7'b0000001 || out_valid !== 1'b1 || index !== 3'd0) begin
         errors++;
         $display("FAIL overrun_set: got ovr=%b data=%b valid=%b idx=%0d, want 1 0000001 1 0",
                  overrun, out_data, out_valid, index);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (overrun !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_sticky: got ovr=%b valid=%b, want 1 0", overrun, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] part;
      part = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1;
         bit_in    = part[i];
         tick();
      end
      bit_valid = 1'b0;
      Resetn = 1'b0;
      #1;
      checks++;
      if ({out_data, out_valid, index, overrun, parity_err} !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got data=%b valid=%b idx=%0d ovr=%b perr=%b, want all 0",
                  out_data, out_valid, index, overrun, parity_err);
      end
      tick();
      Resetn = 1'b1;
      send_word(7'b1111111, 1'b1); // seven ones -> parity 1
      checks++;
      if (out_data !== 7'b1111111 || out_valid !== 1'b1 || index !== 3'd0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_word: got data=%b valid=%b idx=%0d ovr=%b, want 1111111 1 0 0",
                  out_data, out_valid, index, overrun);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

`ifdef SERIAL_DEMUX7_PARITY_EN
   task automatic test_parity();
      send_word(7'b0000001, 1'b0); // wrong parity bit
      checks++;
      if (parity_err !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL parity_bad: got perr=%b valid=%b, want 1 1", parity_err, out_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clear: got perr=%b, want 0", parity_err);
      end
      send_word(7'b0000001, 1'b1); // correct parity bit
      checks++;
      if (parity_err !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL parity_good: got perr=%b valid=%b, want 0 1", parity_err, out_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_hold_wait();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
`ifdef SERIAL_DEMUX7_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
